// File: rtl/buf_store_engine.sv
// rtl/buf_store_engine.sv - drains the coprocessor staging buffer into memory, one write command per word
// Optional BUF_STORE_ERR_ABORT_EN: an error response ends the transfer immediately.
module buf_store_engine #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [4:0]    word_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          buf_rd_en,
  input  logic [DW-1:0] buf_rd_data,
  output logic          mem_cmd_valid,
  input  logic          mem_cmd_ready,
  output logic [AW-1:0] mem_cmd_addr,
  output logic [DW-1:0] mem_cmd_wdata,
  output logic          mem_cmd_read,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic          mem_rsp_err
);

  typedef enum logic [2:0] {IDLE, FETCH, CMD, RSP, DONE} state_t;

  localparam logic [4:0]    MAX_CNT  = 5'(DEPTH);
  localparam logic [AW-1:0] ADDR_INC = AW'(4);

  state_t     state;
  logic [4:0] remain;
  logic       last_word;

  assign mem_cmd_read = 1'b0;
`ifdef BUF_STORE_ERR_ABORT_EN
  assign last_word = (remain == 5'd1) || mem_rsp_err;
`else
  assign last_word = (remain == 5'd1);
`endif

  // mem_cmd_addr and mem_cmd_wdata double as the address and data holding registers,
  // so they cannot move while a command waits for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remain        <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      buf_rd_en     <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= '0;
      mem_rsp_ready <= 1'b0;
    end else begin
      done      <= 1'b0;
      buf_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_cmd_addr <= base_addr;
            err          <= 1'b0;
            busy         <= 1'b1;
            if (word_cnt == 5'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              remain    <= (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;
              buf_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          mem_cmd_wdata <= buf_rd_data;
          mem_cmd_valid <= 1'b1;
          state         <= CMD;
        end
        CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            mem_rsp_ready <= 1'b0;
            mem_cmd_addr  <= mem_cmd_addr + ADDR_INC;
            remain        <= remain - 5'd1;
            if (mem_rsp_err) err <= 1'b1;
            if (last_word) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              buf_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_store_engine.sv
// tb/tb_buf_store_engine.sv - directed bench for buf_store_engine with buffer and memory models
// Expectations follow BUF_STORE_ERR_ABORT_EN when it is defined.
module tb_buf_store_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [4:0]  word_cnt = '0;
  logic        busy, done, err, buf_rd_en;
  logic [31:0] buf_rd_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b1;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic        mem_cmd_read;
  logic        mem_rsp_valid = 1'b1;
  logic        mem_rsp_ready;
  logic        mem_rsp_err = 1'b0;

  int vec = 0;
  int miss = 0;

  buf_store_engine dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .err(err), .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_read(mem_cmd_read), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  // Staging buffer model: entry i holds 0x11111111*(i+1).
  logic [31:0] buf_mem [16];
  logic [3:0]  rd_ptr = '0;
  logic        buf_rst = 1'b0;
  initial for (int i = 0; i < 16; i++) buf_mem[i] = 32'h11111111 * (i + 1);
  assign buf_rd_data = buf_mem[rd_ptr];
  always @(posedge clk) begin
    if (buf_rst) rd_ptr <= '0;
    else if (buf_rd_en) rd_ptr <= rd_ptr + 4'd1;
  end

  // Monitor, sampled at the falling edge; cycle 0 is the one where start is accepted.
  int          cyc_ne = 0, t_start = 0, rd_cnt = 0, cmd_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic [31:0] cmd_addr [32];
  logic [31:0] cmd_data [32];
  logic        hold_v = 1'b0, stab_bad = 1'b0;
  logic [31:0] hold_a = '0, hold_d = '0;

  always @(negedge clk) begin
    cyc_ne <= cyc_ne + 1;
    if (start && !busy && !rst) begin
      t_start  <= cyc_ne;
      rd_cnt   <= 0;
      cmd_cnt  <= 0;
      done_cnt <= 0;
      done_cyc <= -1;
      stab_bad <= 1'b0;
      hold_v   <= 1'b0;
    end else begin
      if (buf_rd_en) rd_cnt <= rd_cnt + 1;
      if (mem_cmd_valid && mem_cmd_ready) begin
        cmd_addr[cmd_cnt[4:0]] <= mem_cmd_addr;
        cmd_data[cmd_cnt[4:0]] <= mem_cmd_wdata;
        cmd_cnt <= cmd_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc_ne - t_start;
      end
      hold_v <= mem_cmd_valid && !mem_cmd_ready;
      hold_a <= mem_cmd_addr;
      hold_d <= mem_cmd_wdata;
      if (hold_v && (mem_cmd_addr !== hold_a || mem_cmd_wdata !== hold_d)) stab_bad <= 1'b1;
    end
  end

  task automatic reset_buf();
    buf_rst = 1'b1;
    @(posedge clk); #1;
    buf_rst = 1'b0;
  endtask

  // Issue one transfer and run the memory model until busy drops.
  task automatic go(input logic [4:0] cnt, input logic [31:0] base, input int stall_word,
                    input int stall_cycles, input int err_word, input int extra_start_at);
    int  stall_left;
    bit  fin;
    stall_left = stall_cycles;
    fin = 0;
    @(posedge clk); #1;
    start = 1'b1; word_cnt = cnt; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      start = (i == extra_start_at);
      if (start) begin word_cnt = 5'd7; base_addr = 32'h0000_8000; end
      if (mem_cmd_valid && cmd_cnt == stall_word - 1 && stall_left > 0) begin
        mem_cmd_ready = 1'b0;
        stall_left--;
      end else begin
        mem_cmd_ready = 1'b1;
      end
      mem_rsp_err = (cmd_cnt == err_word);
      @(posedge clk); #1;
      fin = (done_cnt > 0) && !busy;
    end
    start = 1'b0;
    mem_cmd_ready = 1'b1;
    mem_rsp_err = 1'b0;
    vec++;
    if (!fin) begin miss++; $display("FAIL timeout: transfer cnt=%0d never completed", cnt); end
  endtask

  task automatic check_cmds(input string name, input logic [31:0] base, input int n);
    logic [31:0] ea, ed;
    for (int k = 0; k < n; k++) begin
      ea = base + 32'(4 * k);
      ed = 32'h11111111 * (k + 1);
      vec++;
      if (cmd_addr[k] !== ea) begin
        miss++; $display("FAIL %s addr[%0d]: got %h expected %h", name, k, cmd_addr[k], ea);
      end
      vec++;
      if (cmd_data[k] !== ed) begin
        miss++; $display("FAIL %s data[%0d]: got %h expected %h", name, k, cmd_data[k], ed);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vec++;
    if ({busy, done, err, buf_rd_en, mem_cmd_valid, mem_rsp_ready, mem_cmd_read} !== 7'b0) begin
      miss++;
      $display("FAIL %s ctrl: got busy%b done%b err%b rd%b cv%b rr%b rd%b expected all 0", name,
               busy, done, err, buf_rd_en, mem_cmd_valid, mem_rsp_ready, mem_cmd_read);
    end
    vec++;
    if (mem_cmd_addr !== 32'h0 || mem_cmd_wdata !== 32'h0) begin
      miss++; $display("FAIL %s bus: got addr %h wdata %h expected 0", name, mem_cmd_addr, mem_cmd_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    reset_buf();
  endtask

  task automatic test_zero_count();
    go(5'd0, 32'h0000_2000, 0, 0, 0, -1);
    vec++; if (done_cyc !== 1) begin miss++; $display("FAIL zero done_cycle: got %0d expected 1", done_cyc); end
    vec++; if (rd_cnt !== 0) begin miss++; $display("FAIL zero reads: got %0d expected 0", rd_cnt); end
    vec++; if (cmd_cnt !== 0) begin miss++; $display("FAIL zero cmds: got %0d expected 0", cmd_cnt); end
  endtask

  task automatic test_basic();
    reset_buf();
    go(5'd4, 32'h0000_1000, 0, 0, 0, -1);
    check_cmds("basic", 32'h0000_1000, 4);
    vec++; if (done_cyc !== 13) begin miss++; $display("FAIL basic done_cycle: got %0d expected 13", done_cyc); end
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL basic err: got %b expected 0", err); end
    vec++; if (rd_cnt !== 4) begin miss++; $display("FAIL basic reads: got %0d expected 4", rd_cnt); end
  endtask

  task automatic test_stall();
    reset_buf();
    go(5'd3, 32'h0000_1000, 2, 5, 0, -1);
    check_cmds("stall", 32'h0000_1000, 3);
    vec++; if (stab_bad !== 1'b0) begin miss++; $display("FAIL stall stable: got unstable=%b expected 0", stab_bad); end
    vec++; if (rd_cnt !== 3) begin miss++; $display("FAIL stall reads: got %0d expected 3", rd_cnt); end
    vec++; if (done_cyc !== 15) begin miss++; $display("FAIL stall done_cycle: got %0d expected 15", done_cyc); end
  endtask

  task automatic test_rsp_err();
    int exp_cmds, exp_done;
`ifdef BUF_STORE_ERR_ABORT_EN
    exp_cmds = 2; exp_done = 7;
`else
    exp_cmds = 4; exp_done = 13;
`endif
    reset_buf();
    go(5'd4, 32'h0000_3000, 0, 0, 2, -1);
    vec++; if (cmd_cnt !== exp_cmds) begin miss++; $display("FAIL rsp_err cmds: got %0d expected %0d", cmd_cnt, exp_cmds); end
    vec++; if (rd_cnt !== exp_cmds) begin miss++; $display("FAIL rsp_err reads: got %0d expected %0d", rd_cnt, exp_cmds); end
    vec++; if (done_cyc !== exp_done) begin miss++; $display("FAIL rsp_err done_cycle: got %0d expected %0d", done_cyc, exp_done); end
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL rsp_err err: got %b expected 1", err); end
    reset_buf();
    go(5'd1, 32'h0000_3000, 0, 0, 0, -1);
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL err_clear err: got %b expected 0", err); end
  endtask

  task automatic test_clamp_wrap();
    reset_buf();
    go(5'd20, 32'hFFFF_FFF8, 0, 0, 0, -1);
    vec++; if (cmd_cnt !== 16) begin miss++; $display("FAIL clamp cmds: got %0d expected 16", cmd_cnt); end
    vec++; if (rd_cnt !== 16) begin miss++; $display("FAIL clamp reads: got %0d expected 16", rd_cnt); end
    vec++; if (done_cyc !== 49) begin miss++; $display("FAIL clamp done_cycle: got %0d expected 49", done_cyc); end
    vec++; if (cmd_addr[2] !== 32'h0) begin miss++; $display("FAIL wrap addr[2]: got %h expected 00000000", cmd_addr[2]); end
    check_cmds("clamp", 32'hFFFF_FFF8, 16);
  endtask

  task automatic test_back_to_back();
    reset_buf();
    go(5'd2, 32'h0000_4000, 0, 0, 0, 1);
    vec++; if (cmd_cnt !== 2) begin miss++; $display("FAIL busy_start cmds: got %0d expected 2", cmd_cnt); end
    vec++; if (done_cyc !== 7) begin miss++; $display("FAIL busy_start done_cycle: got %0d expected 7", done_cyc); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL busy_start busy: got %b expected 0", busy); end
    reset_buf();
    go(5'd2, 32'h0000_5000, 0, 0, 0, -1);
    check_cmds("b2b", 32'h0000_5000, 2);
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 0;
    reset_buf();
    @(posedge clk); #1;
    start = 1'b1; word_cnt = 5'd4; base_addr = 32'h0000_6000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      mem_cmd_ready = (cmd_cnt == 0);
      @(posedge clk); #1;
      hit = mem_cmd_valid && (cmd_cnt == 1);
    end
    vec++;
    if (!hit) begin miss++; $display("FAIL mid_reset: never reached CMD of word 2"); end
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    mem_cmd_ready = 1'b1;
    reset_buf();
    go(5'd1, 32'h0000_7000, 0, 0, 0, -1);
    vec++; if (done_cyc !== 4) begin miss++; $display("FAIL post_reset done_cycle: got %0d expected 4", done_cyc); end
    check_cmds("post_reset", 32'h0000_7000, 1);
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_basic();
    test_stall();
    test_rsp_err();
    test_clamp_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/buf_store_engine.md
# buf_store_engine

Drain side of the 32-bit × 16-entry coprocessor staging buffer. Given a start pulse, a base address and a word count, it pops words out of the buffer one at a time and writes each one to memory through a valid/ready command channel with a response channel. It sits between the staging buffer's read port and the coprocessor memory interface, and reports completion and error status back to the instruction control logic.

## Interface
Parameters:
- DW, 32, data word width; matches buffer width.
- AW, 32, memory address width.
- DEPTH, 16, buffer depth; maximum words per transfer.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  AW  byte address of first word; latched on accepted start.
- word_cnt  in  5  number of words; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends.
- err  out  1  sticky error flag; cleared on the next accepted start.
- buf_rd_en  out  1  buffer read strobe; one cycle per word.
- buf_rd_data  in  DW  buffer read data; valid combinationally in the same cycle as buf_rd_en.
- mem_cmd_valid  out  1  memory write command valid.
- mem_cmd_ready  in  1  memory write command ready.
- mem_cmd_addr  out  AW  write address.
- mem_cmd_wdata  out  DW  write data.
- mem_cmd_read  out  1  constant 0 (write only).
- mem_rsp_valid  in  1  write response valid.
- mem_rsp_ready  out  1  high only in RSP.
- mem_rsp_err  in  1  response error; qualified by mem_rsp_valid.

## Operation
- FSM states: IDLE, FETCH, CMD, RSP, DONE. Reset value is IDLE.
- Reset value of every output: busy=0, done=0, err=0, buf_rd_en=0, mem_cmd_valid=0, mem_cmd_addr=0, mem_cmd_wdata=0, mem_rsp_ready=0.
- IDLE, start=1: latch addr_q=base_addr and clear err.
  - If word_cnt is 0, go to DONE with no buffer reads.
  - If word_cnt is 1–16, set remain=word_cnt and go to FETCH.
  - If word_cnt is 17–31, clamp to DEPTH (16) and go to FETCH.
- FETCH: assert buf_rd_en for exactly this one cycle and capture buf_rd_data into wdata_q. Go to CMD.
- CMD: assert mem_cmd_valid with addr_q and wdata_q. Address and data must stay stable until the handshake completes. On mem_cmd_valid & mem_cmd_ready, go to RSP.
- RSP: assert mem_rsp_ready. On mem_rsp_valid:
  - Set err if mem_rsp_err=1.
  - Update addr_q += 4 (modulo 2^AW; wraps silently) and remain -= 1.
  - If remain was 1, go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy is ignored; no queueing.
- No under-run check. The buffer exposes no empty flag, so the issuer must only request words already written. Reading past the written data returns stale entries and advances the buffer read pointer.
- Reset in mid-transfer: return to IDLE next cycle, with all outputs at their reset values. Any in-flight memory response is dropped. The buffer read pointer is not restored; the buffer must also be reset.

## Timing
- Start is sampled at cycle 0; the first buf_rd_en is in cycle 1.
- Each word takes FETCH 1 + CMD ≥1 + RSP ≥1 cycles. With zero wait states this is 3 cycles per word.
- For N words at zero wait, done is high in cycle 3N+1. For word_cnt=0, done is high in cycle 1.
- The response cannot be accepted in the same cycle as its command handshake.
- At most one outstanding command at a time.
- busy falls in the cycle after done.

## Configuration
- Macro: BUF_STORE_ERR_ABORT_EN.
- Defined: when a response has mem_rsp_err=1, set err and go straight to DONE. Remaining words stay in the buffer, unread.
- Undefined: set err (sticky) and continue the transfer to the full count; done timing is unchanged.

## Test plan
- Reset, then check every output is 0 and the state is IDLE. Assert start with word_cnt=0 -> done in cycle 1, zero buf_rd_en pulses, zero commands.
- Buffer preloaded with 0x11111111..0x44444444; base=0x1000, cnt=4, zero-wait memory -> writes to 0x1000/0x1004/0x1008/0x100C with matching data, done in cycle 13, err=0.
- cnt=3, mem_cmd_ready held low 5 cycles on word 2 -> addr and wdata stay stable throughout, exactly 3 buf_rd_en pulses, done in cycle 15.
- cnt=4, mem_rsp_err=1 on word 2:
  - With the macro defined: 2 commands issued, then done with err=1.
  - Without the macro: 4 commands issued, done in cycle 13, err=1.
  - Next start clears err.
- cnt=20 -> clamped to 16 commands; base=0xFFFFFFF8 -> the third address wraps to 0x00000000.
- rst asserted while in CMD of word 2 -> IDLE next cycle with all outputs 0. A start pulse during busy has no effect.
